// File: rtl/spi_mem_load_ctrl.sv
// SPI program loader: assembles SPI bytes into address/data words, issues memory
// writes and read-backs, and hands the shared memory port to the core on core_select.
module spi_mem_load_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_select,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  core_we,
  input  logic                  core_re,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_rst_n,
  output logic                  load_busy,
  output logic [CNT_WIDTH-1:0]  write_count
);

  localparam logic [2:0] ST_ADDR    = 3'd0;
  localparam logic [2:0] ST_DATA    = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD_TX   = 3'd5;

  logic                  sel_q, core_rst_n_q;
  logic [2:0]            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, word_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic [CNT_WIDTH-1:0]  write_count_q, write_count_d;

  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign word_next = {rx_byte, word_q[DATA_WIDTH-1:8]};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rd_buf_d      = rd_buf_q;
    tx_byte_d     = tx_byte_q;
    write_count_d = write_count_q;

    if (sel_q) begin
      state_d    = ST_ADDR;
      byte_cnt_d = 2'd0;
      tx_byte_d  = 8'd0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (rx_valid) begin
            word_d     = word_next;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (state_q == ST_ADDR) begin
                addr_d  = ADDR_WIDTH'(word_next >> 1);
                state_d = word_next[0] ? ST_DATA : ST_RD_REQ;
              end else begin
                data_d  = word_next;
                state_d = ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          state_d = ST_ADDR;
          if (write_count_q != {CNT_WIDTH{1'b1}}) write_count_d = write_count_q + 1'b1;
        end
        ST_RD_REQ: state_d = ST_RD_WAIT;
        ST_RD_WAIT: begin
          rd_buf_d  = mem_rdata;
          tx_byte_d = mem_rdata[7:0];
          state_d   = ST_RD_TX;
        end
        ST_RD_TX: begin
          // Incoming bytes are dummies; each one only clocks out the next read byte.
          if (rx_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            rd_buf_d   = rd_buf_q >> 8;
            if (byte_cnt_q == 2'd3) begin
              tx_byte_d = 8'd0;
              state_d   = ST_ADDR;
            end else begin
              tx_byte_d = rd_buf_q[15:8];
            end
          end
        end
        default: state_d = ST_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= 1'b0;
      core_rst_n_q  <= 1'b0;
      state_q       <= ST_ADDR;
      byte_cnt_q    <= 2'd0;
      word_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      rd_buf_q      <= '0;
      tx_byte_q     <= 8'd0;
      write_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sel_q         <= core_select;
      core_rst_n_q  <= sel_q;
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      rd_buf_q      <= rd_buf_d;
      tx_byte_q     <= tx_byte_d;
      write_count_q <= write_count_d;
    end
  end

  assign mem_addr    = sel_q ? core_addr  : addr_q;
  assign mem_wdata   = sel_q ? core_wdata : data_q;
  assign mem_we      = sel_q ? core_we    : (state_q == ST_WRITE);
  assign mem_re      = sel_q ? core_re    : (state_q == ST_RD_REQ);
  assign core_rdata  = sel_q ? mem_rdata  : '0;
  assign core_rst_n  = core_rst_n_q;
  assign tx_byte     = tx_byte_q;
  assign load_busy   = (byte_cnt_q != 2'd0) || (state_q != ST_ADDR);
  assign write_count = write_count_q;

endmodule

// File: tb/tb_spi_mem_load_ctrl.sv
// Self-checking bench for spi_mem_load_ctrl: random write/read traffic against a
// word-level memory model, core hand-over, aborts, async reset and counter saturation.
module tb_spi_mem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_select = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_wdata = 32'd0;
  logic        core_we = 1'b0;
  logic        core_re = 1'b0;

  logic [7:0]  tx_byte, tx_byte_c1;
  logic [31:0] mem_addr, mem_addr_c1, mem_wdata, mem_wdata_c1;
  logic        mem_we, mem_we_c1, mem_re, mem_re_c1;
  logic [31:0] core_rdata, core_rdata_c1;
  logic        core_rst_n, core_rst_n_c1, load_busy, load_busy_c1;
  logic [15:0] write_count;
  logic [0:0]  write_count_c1;

  always #5 clk = ~clk;

  spi_mem_load_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .core_select(core_select), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_we(core_we), .core_re(core_re),
    .core_rdata(core_rdata), .core_rst_n(core_rst_n), .load_busy(load_busy),
    .write_count(write_count)
  );

  spi_mem_load_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .core_select(core_select), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte_c1), .mem_addr(mem_addr_c1),
    .mem_wdata(mem_wdata_c1), .mem_we(mem_we_c1), .mem_re(mem_re_c1),
    .mem_rdata(mem_rdata), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_we(core_we), .core_re(core_re), .core_rdata(core_rdata_c1),
    .core_rst_n(core_rst_n_c1), .load_busy(load_busy_c1), .write_count(write_count_c1)
  );

  // Memory attached to the shared port, plus the reference view of its contents.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [63:0] obs_q [$];
  int          exp_wc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
  end

  always @(negedge clk) if (mem_we) obs_q.push_back({mem_addr, mem_wdata});

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (write_count !== 16'(exp_wc)) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, write_count, exp_wc);
    end
    checks++;
    if (write_count_c1 !== ((exp_wc > 0) ? 1'b1 : 1'b0)) begin
      errors++;
      $display("FAIL %s write_count_c1: got %0d expected %0d", tag, write_count_c1,
               (exp_wc > 0) ? 1 : 0);
    end
  endtask

  task automatic do_write(input logic [30:0] a, input logic [31:0] d);
    logic [63:0] got;
    obs_q.delete();
    send_word({a, 1'b1});
    send_word(d);
    ref_mem[{1'b0, a}] = d;
    exp_wc++;
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL wr_count_cycles @%h: got %0d we cycles expected 1", a, obs_q.size());
    end else begin
      got = obs_q[0];
      checks++;
      if (got !== {1'b0, a, d}) begin
        errors++;
        $display("FAIL wr_addr_data: got %h/%h expected %h/%h", got[63:32], got[31:0],
                 {1'b0, a}, d);
      end
    end
    check_counts("write");
  endtask

  task automatic do_read(input logic [30:0] a);
    logic [31:0] exp;
    exp = ref_read({1'b0, a});
    obs_q.delete();
    send_word({a, 1'b0});
    checks++;
    if (load_busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_busy: got %b expected 1", load_busy);
    end
    checks++;
    if (core_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rd_core_rdata_gated: got %h expected 0", core_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_byte !== exp[8*i +: 8]) begin
        errors++;
        $display("FAIL rd_tx_byte%0d @%h: got %h expected %h", i, a, tx_byte, exp[8*i +: 8]);
      end
      send_byte(8'($urandom));
    end
    checks++;
    if (tx_byte !== 8'd0 || load_busy !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL rd_end: got tx=%h busy=%b writes=%0d expected 00/0/0", tx_byte,
               load_busy, obs_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_byte, mem_we, mem_re, core_rst_n, load_busy} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%h we=%b re=%b crst=%b busy=%b expected all 0",
               tx_byte, mem_we, mem_re, core_rst_n, load_busy);
    end
    check_counts("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    do_write(31'd0, 32'h0000_0513);
  endtask

  task automatic test_write_read();
    do_write(31'd2, 32'hDEAD_BEEF);
    do_read(31'd2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(1, 0) == 1) do_write(31'($urandom_range(15, 0)), $urandom);
      else do_read(31'($urandom_range(15, 0)));
    end
  endtask

  task automatic test_core_handover();
    logic [31:0] ca, cd;
    do_write(31'd7, 32'h1234_5678);
    ca = 32'd100 + 32'($urandom_range(50, 0));
    cd = $urandom;
    @(negedge clk);
    core_select = 1'b1;
    core_addr   = ca;
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0 || mem_addr !== ca) begin
      errors++;
      $display("FAIL handover_1clk: got crst=%b addr=%h expected 0/%h", core_rst_n, mem_addr, ca);
    end
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL handover_2clk core_rst_n: got %b expected 1", core_rst_n);
    end
    core_we = 1'b1;
    core_wdata = cd;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== cd || mem_addr !== ca) begin
      errors++;
      $display("FAIL core_mux_write: got we=%b d=%h a=%h expected 1/%h/%h", mem_we, mem_wdata,
               mem_addr, cd, ca);
    end
    @(negedge clk);
    core_we = 1'b0;
    ref_mem[ca] = cd;
    send_word({31'd9, 1'b1});
    send_word($urandom);
    checks++;
    if (load_busy !== 1'b0 || tx_byte !== 8'd0) begin
      errors++;
      $display("FAIL core_rx_ignored: got busy=%b tx=%h expected 0/00", load_busy, tx_byte);
    end
    check_counts("core_mode");
    core_addr = 32'd2;
    core_re = 1'b1;
    @(negedge clk);
    core_re = 1'b0;
    checks++;
    if (core_rdata !== ref_read(32'd2)) begin
      errors++;
      $display("FAIL core_read: got %h expected %h", core_rdata, ref_read(32'd2));
    end
    core_select = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL core_reassert_reset: got %b expected 0", core_rst_n);
    end
    do_write(31'd11, 32'hCAFE_F00D);
  endtask

  task automatic test_partial_abort();
    obs_q.delete();
    send_byte(8'h0B);
    send_byte(8'h00);
    checks++;
    if (load_busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_busy: got %b expected 1", load_busy);
    end
    core_select = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (load_busy !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL partial_discard: got busy=%b writes=%0d expected 0/0", load_busy,
               obs_q.size());
    end
    core_select = 1'b0;
    repeat (3) @(negedge clk);
    do_write(31'd5, 32'hA5A5_0F0F);
  endtask

  task automatic test_async_reset();
    obs_q.delete();
    send_word({31'd6, 1'b1});
    send_byte(8'h11);
    send_byte(8'h22);
    #3;
    rst_n = 1'b0;
    #1;
    exp_wc = 0;
    checks++;
    if ({tx_byte, mem_we, mem_re, core_rst_n, load_busy} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got tx=%h we=%b re=%b crst=%b busy=%b expected 0",
               tx_byte, mem_we, mem_re, core_rst_n, load_busy);
    end
    check_counts("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL async_reset_no_write: got %0d writes expected 0", obs_q.size());
    end
    do_write(31'd6, 32'h0BAD_F00D);
    do_read(31'd2);
  endtask

  task automatic test_saturation();
    do_write(31'd12, 32'h1);
    do_write(31'd13, 32'h2);
    checks++;
    if (write_count_c1 !== 1'b1) begin
      errors++;
      $display("FAIL saturation: got %0d expected 1", write_count_c1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_write_read();
    test_random();
    test_core_handover();
    test_partial_abort();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
